// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS fetch front end: FSM state
// encoding, pc_src selector codes, word size and the default reset vector.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Fetch driver FSM states
  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_EXEC = 3'd2,
    ST_UPDATE    = 3'd3,
    ST_FAULT     = 3'd4
  } fetch_state_e;

  // Control-flow source reported by the execute stages
  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2,
    PC_SRC_REG    = 2'd3
  } pc_src_e;

  // A target is a legal fetch address only if it sits on a word boundary
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch driver.
// Ports:
//   i_pc_cur        current PC
//   i_pc_src        0 seq, 1 branch, 2 jump, 3 register
//   i_branch_taken  qualifies the branch source
//   i_imm16         branch offset in words
//   i_jtarget       26-bit jump index
//   i_rtarget       register (jr) target
//   o_target_c      selected next PC
//   o_misaligned_c  selected target is not word aligned
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] i_pc_cur,
  input  logic [1:0]       i_pc_src,
  input  logic             i_branch_taken,
  input  logic [15:0]      i_imm16,
  input  logic [25:0]      i_jtarget,
  input  logic [WIDTH-1:0] i_rtarget,
  output logic [WIDTH-1:0] o_target_c,
  output logic             o_misaligned_c
);

  logic [WIDTH-1:0] w_p4;
  logic [WIDTH-1:0] w_br_off;
  logic [WIDTH-1:0] w_jump;

  // Sequential address wraps naturally at the top of the address space
  assign w_p4     = i_pc_cur + WIDTH'(WORD_BYTES);
  // Word offset -> sign-extended byte offset
  assign w_br_off = {{(WIDTH-18){i_imm16[15]}}, i_imm16, 2'b00};
  // Jump stays inside the 256 MB region of the delay-slot address
  assign w_jump   = {w_p4[WIDTH-1:28], i_jtarget, 2'b00};

  // Target select
  always_comb begin
    o_target_c = w_p4;
    case (pc_src_e'(i_pc_src))
      PC_SRC_SEQ:    o_target_c = w_p4;
      PC_SRC_BRANCH: o_target_c = i_branch_taken ? (w_p4 + w_br_off) : w_p4;
      PC_SRC_JUMP:   o_target_c = w_jump;
      PC_SRC_REG:    o_target_c = i_rtarget;
      default:       o_target_c = w_p4;
    endcase
  end

  assign o_misaligned_c = !is_word_aligned(o_target_c[1:0]);

endmodule

// File: rtl/pc_fetch_driver.sv
// Program-counter driver for the multicycle MIPS core. Loads the PC register
// via pc_next/hit, fetches the instruction at the current PC over a req/ack
// handshake into an instruction register, then waits for execute to report
// control flow and loads the selected target.
// Ports:
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   pc_cur                PC register output
//   pc_next, hit          PC register input and one-cycle load strobe
//   mem_req, mem_addr     instruction read request / address
//   mem_ack, mem_rdata    read data valid / instruction word
//   instr, instr_valid    instruction register and its valid flag
//   exec_done             execute finished current instruction
//   pc_src, branch_taken, imm16, jtarget, rtarget   control-flow inputs
//   fault                 sticky fetch-timeout / misaligned-target flag
module pc_fetch_driver
  import mips_pkg::*;
#(
  parameter int unsigned     WIDTH        = XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned     TIMEOUT      = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_next,
  output logic             hit,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic [1:0]       pc_src,
  input  logic             branch_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jtarget,
  input  logic [WIDTH-1:0] rtarget,
  output logic             fault
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_e     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc_next, w_pc_next_nxt;
  logic             r_hit, w_hit_nxt;
  logic             r_mem_req, w_mem_req_nxt;
  logic [WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]      r_instr, w_instr_nxt;
  logic             r_instr_valid, w_instr_valid_nxt;
  logic             r_fault, w_fault_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_target;
  logic             w_misaligned;

  next_pc_calc #(.WIDTH(WIDTH)) u_next_pc_calc (
    .i_pc_cur       (pc_cur),
    .i_pc_src       (pc_src),
    .i_branch_taken (branch_taken),
    .i_imm16        (imm16),
    .i_jtarget      (jtarget),
    .i_rtarget      (rtarget),
    .o_target_c     (w_target),
    .o_misaligned_c (w_misaligned)
  );

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_INIT;
      r_pc_next     <= RESET_VECTOR;
      r_hit         <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc_next     <= w_pc_next_nxt;
      r_hit         <= w_hit_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_fault       <= w_fault_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_next_nxt     = r_pc_next;
    w_hit_nxt         = 1'b0;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_fault_nxt       = r_fault;
    w_cnt_nxt         = r_cnt;

    case (r_state)
      ST_INIT: begin
        w_pc_next_nxt = RESET_VECTOR;
        w_hit_nxt     = 1'b1;
        w_state_nxt   = ST_FETCH;
      end

      ST_FETCH: begin
        if (!r_mem_req) begin
          // While hit is high the PC register is still loading, so pc_cur
          // is stale; issue the request one cycle later.
          if (!r_hit) begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = pc_cur;
            w_cnt_nxt      = '0;
          end
        end else if (mem_ack) begin
          w_instr_nxt       = mem_rdata;
          w_instr_valid_nxt = 1'b1;
          w_mem_req_nxt     = 1'b0;
          w_cnt_nxt         = '0;
          w_state_nxt       = ST_WAIT_EXEC;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_fault_nxt   = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = ST_FAULT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_WAIT_EXEC: begin
        if (exec_done) begin
          if (w_misaligned) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_FAULT;
          end else begin
            w_pc_next_nxt = w_target;
            w_hit_nxt     = 1'b1;
            w_state_nxt   = ST_UPDATE;
          end
        end
      end

      ST_UPDATE: begin
        w_instr_valid_nxt = 1'b0;
        w_state_nxt       = ST_FETCH;
      end

      ST_FAULT: begin
        w_mem_req_nxt = 1'b0;
        w_fault_nxt   = 1'b1;
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign pc_next     = r_pc_next;
  assign hit         = r_hit;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fault       = r_fault;

endmodule

// File: tb/tb_pc_fetch_driver.sv
// Scoreboard bench for pc_fetch_driver: the driver plays instruction memory
// and execute stages, a monitor process checks hit/pc_next, fetch addresses
// and captured instructions against queued expectations.
module tb_pc_fetch_driver;

  localparam int unsigned     TO = 4;
  localparam logic [31:0]     RV = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] rtarget;
  logic        fault;

  logic [31:0] pc_reg = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_hit[$];
  logic [31:0] q_addr[$];
  logic [31:0] q_instr[$];
  logic [31:0] exp_pc;

  typedef struct {
    logic [1:0]  src;
    logic        taken;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] rt;
    int          dly;
    logic [31:0] data;
  } op_t;

  pc_fetch_driver #(.WIDTH(32), .RESET_VECTOR(RV), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc_cur       (pc_cur),
    .pc_next      (pc_next),
    .hit          (hit),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jtarget      (jtarget),
    .rtarget      (rtarget),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  // The core's PC register: loads pc_next on hit
  always @(posedge clock) if (hit) pc_reg <= pc_next;
  assign pc_cur = pc_reg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // Architectural next-PC rule
  function automatic logic [31:0] ref_target(input logic [31:0] pc, input op_t e);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    case (e.src)
      2'd0:    return p4;
      2'd1:    return e.taken ? p4 + 32'(int'($signed(e.imm)) * 4) : p4;
      2'd2:    return (p4 / 32'h1000_0000) * 32'h1000_0000 + 32'(e.jt) * 32'd4;
      default: return e.rt;
    endcase
  endfunction

  function automatic op_t mk(input logic [1:0] src, input logic taken, input logic [15:0] imm,
                             input logic [25:0] jt, input logic [31:0] rt, input int dly,
                             input logic [31:0] data);
    op_t e;
    e.src = src; e.taken = taken; e.imm = imm; e.jt = jt; e.rt = rt; e.dly = dly; e.data = data;
    return e;
  endfunction

  function automatic op_t rnd_op();
    return mk(2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom), 26'($urandom),
              $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, TO - 1)), $urandom);
  endfunction

  // Monitor: compares DUT events against queued expectations
  task automatic monitor();
    logic prev_hit = 1'b0;
    logic prev_req = 1'b0;
    logic prev_iv  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (hit) begin
          check("hit_single_cycle", {31'd0, prev_hit}, 32'd0);
          if (q_hit.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL hit_unexpected: got hit with pc_next %08h, want no hit", pc_next);
          end else check("pc_next", pc_next, q_hit.pop_front());
        end
        if (mem_req && !prev_req) begin
          check("ivalid_clear_at_req", {31'd0, instr_valid}, 32'd0);
          if (q_addr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL req_unexpected: got mem_req at %08h, want none", mem_addr);
          end else check("mem_addr", mem_addr, q_addr.pop_front());
        end
        if (instr_valid && !prev_iv) begin
          if (q_instr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL ivalid_unexpected: got instr %08h, want none", instr);
          end else check("instr", instr, q_instr.pop_front());
        end
      end
      prev_hit = hit;
      prev_req = mem_req;
      prev_iv  = instr_valid;
    end
  endtask

  // Assert reset; outputs must be at reset values the very next cycle
  task automatic apply_reset(input int cycles);
    reset_n = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    @(negedge clock);
    q_hit.delete(); q_addr.delete(); q_instr.delete();
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_pc_next", pc_next, RV);
    check("rst_instr", instr, 32'd0);
    repeat (cycles - 1) @(negedge clock);
  endtask

  // Release reset: hit with RESET_VECTOR, then mem_req two cycles later
  task automatic release_reset(input logic late_ack);
    reset_n = 1'b1;
    mem_ack = late_ack;
    mem_rdata = 32'hDEAD_BEEF;
    exp_pc = RV;
    q_hit.push_back(RV);
    q_addr.push_back(RV);
    @(negedge clock);
    mem_ack = 1'b0;
    check("init_hit", {31'd0, hit}, 32'd1);
    check("init_ivalid", {31'd0, instr_valid}, 32'd0);
    @(negedge clock);
    check("settle_no_req", {31'd0, mem_req}, 32'd0);
    @(negedge clock);
    check("req_after_init", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic wait_req(output logic ok);
    int n = 0;
    while (!mem_req && n < 16) begin
      @(negedge clock);
      n++;
    end
    ok = mem_req;
  endtask

  // One fetch/execute/update round; returns 1 when target was misaligned
  task automatic run_op(input op_t e, output logic misaligned);
    logic        ok;
    logic [31:0] tgt;
    misaligned = 1'b0;
    wait_req(ok);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_mem_req: got mem_req=0 after 16 cycles, want 1");
    end else begin
      for (int i = 0; i < e.dly; i++) begin
        check("mem_addr_hold", mem_addr, exp_pc);
        mem_ack = 1'b0;
        exec_done = 1'($urandom);
        @(negedge clock);
      end
      mem_ack = 1'b1;
      mem_rdata = e.data;
      exec_done = 1'($urandom);
      q_instr.push_back(e.data);
      @(negedge clock);
      mem_ack = 1'b0;
      exec_done = 1'b0;
      mem_rdata = $urandom;
      check("req_drop", {31'd0, mem_req}, 32'd0);
      check("ivalid_set", {31'd0, instr_valid}, 32'd1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        check("instr_hold", instr, e.data);
      end
      tgt = ref_target(exp_pc, e);
      pc_src = e.src; branch_taken = e.taken; imm16 = e.imm; jtarget = e.jt; rtarget = e.rt;
      exec_done = 1'b1;
      misaligned = (tgt % 32'd4) != 32'd0;
      if (!misaligned) begin
        q_hit.push_back(tgt);
        q_addr.push_back(tgt);
      end
      @(negedge clock);
      exec_done = 1'b0;
      pc_src = 2'($urandom); imm16 = 16'($urandom); rtarget = $urandom | 32'd1;
      check("fault_after_exec", {31'd0, fault}, {31'd0, misaligned});
      if (!misaligned) exp_pc = tgt;
    end
  endtask

  initial begin
    op_t  dir[$];
    logic mis;
    int   cnt;
    int   guard;
    reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; exec_done = 1'b0;
    pc_src = '0; branch_taken = 1'b0; imm16 = '0; jtarget = '0; rtarget = '0;
    fork
      monitor();
    join_none

    apply_reset(3);
    release_reset(1'b0);

    dir.push_back(mk(2'd3, 1'b0, 16'h0,    26'h0,  32'h0000_0100, 0, 32'h0000_0000));
    dir.push_back(mk(2'd0, 1'b0, 16'h0,    26'h0,  32'h0,         3, 32'h8C02_0004));
    dir.push_back(mk(2'd3, 1'b0, 16'h0,    26'h0,  32'h0000_0200, 1, 32'h1111_1111));
    dir.push_back(mk(2'd1, 1'b1, 16'hFFFE, 26'h0,  32'h0,         0, 32'h1000_FFFE));
    dir.push_back(mk(2'd3, 1'b0, 16'h0,    26'h0,  32'h0000_0200, 2, 32'h2222_2222));
    dir.push_back(mk(2'd1, 1'b0, 16'hFFFE, 26'h0,  32'h0,         1, 32'h1000_FFFE));
    dir.push_back(mk(2'd3, 1'b0, 16'h0,    26'h0,  32'h1000_0008, 0, 32'h3333_3333));
    dir.push_back(mk(2'd2, 1'b0, 16'h0,    26'h40, 32'h0,         2, 32'h0800_0040));
    dir.push_back(mk(2'd3, 1'b0, 16'h0,    26'h0,  32'hFFFF_FFFC, 0, 32'h4444_4444));
    dir.push_back(mk(2'd0, 1'b0, 16'h0,    26'h0,  32'h0,         3, 32'h5555_5555));
    foreach (dir[i]) run_op(dir[i], mis);
    repeat (40) run_op(rnd_op(), mis);

    // Misaligned register target: fault, no hit, fetch stops
    run_op(mk(2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1, 32'h6666_6666), mis);
    run_op(mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_0102, 0, 32'h7777_7777), mis);
    repeat (4) begin
      @(negedge clock);
      check("fault_sticky", {31'd0, fault}, 32'd1);
      check("fault_no_req", {31'd0, mem_req}, 32'd0);
    end

    // Fetch timeout with no ack
    apply_reset(2);
    release_reset(1'b0);
    cnt = 0; guard = 0;
    while (!fault && guard < 40) begin
      if (mem_req) cnt++;
      @(negedge clock);
      guard++;
    end
    check("timeout_req_cycles", 32'(cnt), 32'(TO));
    check("timeout_fault", {31'd0, fault}, 32'd1);
    check("timeout_req_low", {31'd0, mem_req}, 32'd0);

    // Reset during an outstanding fetch, then a late ack while in INIT
    apply_reset(2);
    release_reset(1'b0);
    apply_reset(3);
    release_reset(1'b1);
    repeat (6) run_op(rnd_op(), mis);

    repeat (4) @(negedge clock);
    check("q_hit_drained", 32'(q_hit.size()), 32'd0);
    check("q_instr_drained", 32'(q_instr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
